// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU, round-robin on contention.
// Latency: accept to rsp valid is 1 cycle. Backpressure: while a result is held and not taken, no request is accepted.
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int RR_INIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_ctrl,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_ctrl,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_rd
);

    typedef enum logic {IDLE, HOLD} state_e;

    localparam logic PRIO_RST = (RR_INIT != 0);

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic rsp_hs;
    logic slot;
    logic win;
    logic accept;
    logic sel;

    // Only the owner's rsp_ready can open a slot; the other requester's is ignored.
    assign rsp_hs = (state_q == HOLD) && (owner_q ? rsp1_ready : rsp0_ready);
    assign slot   = (state_q == IDLE) || rsp_hs;
    assign win    = (req0_valid && req1_valid) ? prio_q : req1_valid;
    assign accept = slot && (req0_valid || req1_valid);

    assign req0_ready = accept && !win;
    assign req1_ready = accept && win;

    assign sel      = accept ? win : prio_q;
    assign alu_a    = sel ? req1_a    : req0_a;
    assign alu_b    = sel ? req1_b    : req0_b;
    assign alu_ctrl = sel ? req1_ctrl : req0_ctrl;

    assign rsp0_valid = (state_q == HOLD) && !owner_q;
    assign rsp1_valid = (state_q == HOLD) && owner_q;
    assign rsp_data   = rsp_data_q;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        prio_d     = prio_q;
        rsp_data_d = rsp_data_q;
        if (accept) begin
            state_d    = HOLD;
            owner_d    = win;
            prio_d     = !win;
            rsp_data_d = alu_rd;
        end else if (rsp_hs) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            prio_q     <= PRIO_RST;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            prio_q     <= prio_d;
            rsp_data_q <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter against a transaction-level model.
module tb_alu_arbiter;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          r0v, r1v, s0r, s1r;
    logic [W-1:0]  a0, b0, a1, b1;
    logic [3:0]    c0, c1;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [W-1:0]  rsp_data, alu_a, alu_b, alu_rd;
    logic [3:0]    alu_ctrl;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        bit           who;
        logic [W-1:0] data;
    } rsp_t;

    rsp_t q[$];          // results owed to requesters, at most one outstanding
    bit   prio;          // requester favoured on the next contended accept
    int   g0, g1;

    alu_arbiter #(.WIDTH(W), .RR_INIT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(req0_ready), .req0_a(a0), .req0_b(b0), .req0_ctrl(c0),
        .req1_valid(r1v), .req1_ready(req1_ready), .req1_a(a1), .req1_b(b1), .req1_ctrl(c1),
        .rsp0_valid(rsp0_valid), .rsp0_ready(s0r),
        .rsp1_valid(rsp1_valid), .rsp1_ready(s1r),
        .rsp_data(rsp_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_rd(alu_rd)
    );

    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [3:0] c);
        case (c)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0111: return a & b;
            4'b0110: return a | b;
            4'b0010: return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    // The shared ALU sits outside the block.
    always_comb alu_rd = ref_alu(alu_a, alu_b, alu_ctrl);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle with the inputs currently driven: check outputs, then advance the model.
    task automatic step();
        bit hold, own, hs, slot, acc, win;
        #2;
        hold = (q.size() != 0);
        own  = hold ? q[0].who : 1'b0;
        hs   = hold && (own ? s1r : s0r);
        slot = !hold || hs;
        acc  = slot && (r0v || r1v);
        win  = (r0v && r1v) ? prio : r1v;
        check("req0_ready", req0_ready, W'(acc && !win));
        check("req1_ready", req1_ready, W'(acc && win));
        check("rsp0_valid", rsp0_valid, W'(hold && !own));
        check("rsp1_valid", rsp1_valid, W'(hold && own));
        if (hold) check("rsp_data", rsp_data, q[0].data);
        if (acc) begin
            check("alu_a", alu_a, win ? a1 : a0);
            check("alu_ctrl", W'(alu_ctrl), W'(win ? c1 : c0));
        end
        @(posedge clk);
        #1;
        if (hs) void'(q.pop_front());
        if (acc) begin
            q.push_back('{win, win ? ref_alu(a1, b1, c1) : ref_alu(a0, b0, c0)});
            prio = !win;
            if (win) g1++; else g0++;
        end
    endtask

    task automatic idle_inputs();
        r0v = 0; r1v = 0; s0r = 1; s1r = 1;
    endtask

    task automatic drain();
        idle_inputs();
        for (int i = 0; i < 3; i++) step();
    endtask

    initial begin
        rst_n = 0;
        r0v = 0; r1v = 0; s0r = 0; s1r = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; c0 = 0; c1 = 0;
        prio = 1'b0;
        g0 = 0; g1 = 0;
        #1;
        check("reset_rsp0_valid", rsp0_valid, 0);
        check("reset_rsp1_valid", rsp1_valid, 0);
        check("reset_rsp_data", rsp_data, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;

        // Contended first slot: pointer starts at requester 0.
        r0v = 1; a0 = 5;  b0 = 7; c0 = 4'b0000;
        r1v = 1; a1 = 10; b1 = 3; c1 = 4'b1000;
        s0r = 1; s1r = 1;
        step();
        check("r31_rsp0_valid", rsp0_valid, 1);
        check("r31_rsp0_data", rsp_data, 12);
        r0v = 0;
        step();
        check("r31_rsp1_valid", rsp1_valid, 1);
        check("r31_rsp1_data", rsp_data, 7);
        drain();

        // Signed compare on requester 1 alone.
        r1v = 1; a1 = 32'hFFFF_FFFF; b1 = 1; c1 = 4'b0010;
        step();
        r1v = 0; s1r = 0;
        step();
        check("r32_rsp1_valid", rsp1_valid, 1);
        check("r32_rsp0_valid", rsp0_valid, 0);
        check("r32_data", rsp_data, 1);
        drain();

        // Owner stalls for three cycles while the other requester waits.
        r0v = 1; a0 = 32'h30; b0 = 32'h0F; c0 = 4'b0111;
        step();
        r0v = 0; s0r = 0; s1r = 1;
        r1v = 1; a1 = 32'h100; b1 = 32'h1; c1 = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            step();
            check("r33_stall_data", rsp_data, 32'h0);
        end
        s0r = 1;
        #2;
        check("r33_req1_ready", req1_ready, 1);
        step();
        check("r33_rsp1_data", rsp_data, 32'h101);
        drain();

        // Unknown op code yields zero but completes normally.
        r0v = 1; a0 = 32'hFFFF; b0 = 1; c0 = 4'b1111;
        step();
        r0v = 0;
        check("r34_data", rsp_data, 0);
        check("r34_rsp0_valid", rsp0_valid, 1);
        step();
        drain();

        // Asynchronous reset while a result is held.
        r0v = 1; a0 = 32'h10; b0 = 32'h2; c0 = 4'b0000;
        r1v = 1; a1 = 1; b1 = 1; c1 = 4'b0000;
        step();
        step();
        r0v = 0; r1v = 0; s0r = 0; s1r = 0;
        #2;
        check("r35_held_data", rsp_data, 32'h12);
        rst_n = 0;
        #1;
        check("r35_rsp0_valid", rsp0_valid, 0);
        check("r35_rsp1_valid", rsp1_valid, 0);
        check("r35_rsp_data", rsp_data, 0);
        q.delete();
        prio = 1'b0;
        @(posedge clk); #1;
        rst_n = 1;
        s0r = 1; s1r = 1;
        step();
        r0v = 1; r1v = 1;
        #2;
        check("r35_prio_after_reset", req0_ready, 1);
        step();
        drain();

        // Sustained contention: one grant per cycle, alternating.
        g0 = 0; g1 = 0;
        r0v = 1; r1v = 1; s0r = 1; s1r = 1;
        for (int i = 0; i < 10; i++) begin
            a0 = i; b0 = 1; c0 = 4'b0000;
            a1 = i; b1 = 2; c1 = 4'b0000;
            step();
        end
        check("r36_grants0", g0, 5);
        check("r36_grants1", g1, 5);
        drain();

        // Random traffic, including withdrawn requests and non-owner rsp_ready noise.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] ops[6];
            ops = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0010, 4'b1111};
            r0v = 1'($urandom_range(0, 1));
            r1v = 1'($urandom_range(0, 1));
            s0r = ($urandom_range(0, 3) != 0);
            s1r = ($urandom_range(0, 3) != 0);
            a0 = $urandom; b0 = $urandom; c0 = ops[$urandom_range(0, 5)];
            a1 = $urandom; b1 = $urandom; c1 = ops[$urandom_range(0, 5)];
            step();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
